// File: rtl/rv32_pkg.sv
// Shared RV32 execute-stage types: ALU control encodings, M-extension op codes
// and the sequencer state encoding.
package rv32_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        MDU_MUL   = 2'b00,
        MDU_MULHU = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_REMU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_MUL_IT = 2'b01,
        ST_DIV_IT = 2'b10,
        ST_DONE   = 2'b11
    } mdu_state_e;

endpackage

// File: rtl/mdu_alu_sequencer_if.sv
// Request/response handshake plus the borrowed shared-ALU port of the multiply/divide unit.
interface mdu_alu_sequencer_if #(
    parameter int unsigned XLEN = 32
) ();

    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic            alu_own;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] alu_result;
    logic            alu_u_less;

    // Core / execute-stage side
    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready, alu_result, alu_u_less,
        input  req_ready, rsp_valid, rsp_data, alu_own, alu_a, alu_b, alu_ctrl
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready, alu_result, alu_u_less,
        output req_ready, rsp_valid, rsp_data, alu_own, alu_a, alu_b, alu_ctrl
    );

endinterface

// File: rtl/mdu_alu_sequencer.sv
// Multi-cycle MUL/MULHU/DIVU/REMU unit: radix-2 shift-add multiply and restoring
// divide, borrowing the core's shared ALU for one ADD/SUB per iteration.
module mdu_alu_sequencer #(
    parameter int unsigned XLEN       = rv32_pkg::XLEN,
    parameter bit          EARLY_ZERO = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    mdu_alu_sequencer_if.slave  bus
);
    import rv32_pkg::*;

    localparam int unsigned CW = $clog2(XLEN);

    mdu_state_e      state;
    mdu_op_e         op;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    logic            req_ready_q;
    logic            rsp_valid_q;
    logic [XLEN-1:0] rsp_data_q;
    logic            alu_own_q;
    logic [XLEN-1:0] alu_a_q;
    logic [XLEN-1:0] alu_b_q;
    alu_ctrl_e       alu_ctrl_q;

    logic            carry;
    logic            take;
    logic [XLEN-1:0] mul_hi_nxt;
    logic [XLEN-1:0] mul_lo_nxt;
    logic [XLEN-1:0] rs;
    logic [XLEN-1:0] div_r_nxt;
    logic [XLEN-1:0] div_q_nxt;
    logic            req_is_div;
    logic            fast;
    logic [XLEN-1:0] fast_data;

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.alu_own   = alu_own_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_ctrl  = alu_ctrl_q;

    // Per-iteration datapath; hi/lo double as R/Q during division
    always_comb begin
        carry      = 1'b0;
        mul_hi_nxt = '0;
        mul_lo_nxt = '0;
        rs         = '0;
        take       = 1'b0;
        div_r_nxt  = '0;
        div_q_nxt  = '0;

        carry = bus.alu_result < hi;
        if (lo[0]) begin
            mul_hi_nxt = {carry, bus.alu_result[XLEN-1:1]};
            mul_lo_nxt = {bus.alu_result[0], lo[XLEN-1:1]};
        end else begin
            mul_hi_nxt = {1'b0, hi[XLEN-1:1]};
            mul_lo_nxt = {hi[0], lo[XLEN-1:1]};
        end

        // hi[XLEN-1] is the bit shifted out of R; when set, Rs >= divisor regardless of the ALU flag
        rs        = {hi[XLEN-2:0], lo[XLEN-1]};
        take      = hi[XLEN-1] | ~bus.alu_u_less;
        div_r_nxt = take ? bus.alu_result : rs;
        div_q_nxt = {lo[XLEN-2:0], take};
    end

    // Zero-operand shortcut decoded straight from the request
    always_comb begin
        req_is_div = bus.req_op[1];
        fast       = 1'b0;
        fast_data  = '0;
        if (EARLY_ZERO) begin
            fast = req_is_div ? (bus.req_b == '0) : ((bus.req_a == '0) || (bus.req_b == '0));
        end
        case (bus.req_op)
            2'b10:   fast_data = '1;
            2'b11:   fast_data = bus.req_a;
            default: fast_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            op          <= MDU_MUL;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            alu_own_q   <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= ALU_ADD;
        end else if (flush) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            alu_own_q   <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= ALU_ADD;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op          <= mdu_op_e'(bus.req_op);
                        cnt         <= CW'(XLEN - 1);
                        req_ready_q <= 1'b0;
                        hi          <= '0;
                        if (fast) begin
                            rsp_data_q  <= fast_data;
                            rsp_valid_q <= 1'b1;
                            state       <= ST_DONE;
                        end else if (!req_is_div) begin
                            lo         <= bus.req_b;
                            alu_own_q  <= 1'b1;
                            alu_a_q    <= '0;
                            alu_b_q    <= bus.req_a;
                            alu_ctrl_q <= ALU_ADD;
                            state      <= ST_MUL_IT;
                        end else begin
                            lo         <= bus.req_a;
                            alu_own_q  <= 1'b1;
                            alu_a_q    <= XLEN'(bus.req_a[XLEN-1]);
                            alu_b_q    <= bus.req_b;
                            alu_ctrl_q <= ALU_SUB;
                            state      <= ST_DIV_IT;
                        end
                    end
                end
                ST_MUL_IT: begin
                    hi <= mul_hi_nxt;
                    lo <= mul_lo_nxt;
                    if (cnt == '0) begin
                        rsp_data_q  <= (op == MDU_MULHU) ? mul_hi_nxt : mul_lo_nxt;
                        rsp_valid_q <= 1'b1;
                        alu_own_q   <= 1'b0;
                        alu_a_q     <= '0;
                        alu_b_q     <= '0;
                        alu_ctrl_q  <= ALU_ADD;
                        state       <= ST_DONE;
                    end else begin
                        cnt     <= cnt - CW'(1);
                        alu_a_q <= mul_hi_nxt;
                    end
                end
                ST_DIV_IT: begin
                    hi <= div_r_nxt;
                    lo <= div_q_nxt;
                    if (cnt == '0) begin
                        rsp_data_q  <= (op == MDU_REMU) ? div_r_nxt : div_q_nxt;
                        rsp_valid_q <= 1'b1;
                        alu_own_q   <= 1'b0;
                        alu_a_q     <= '0;
                        alu_b_q     <= '0;
                        alu_ctrl_q  <= ALU_ADD;
                        state       <= ST_DONE;
                    end else begin
                        cnt     <= cnt - CW'(1);
                        alu_a_q <= {div_r_nxt[XLEN-2:0], div_q_nxt[XLEN-1]};
                    end
                end
                ST_DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_alu_sequencer.sv
// Directed + randomized bench for mdu_alu_sequencer against a plain-arithmetic
// reference model, with the shared ALU modelled beside the DUT.
module tb_mdu_alu_sequencer;

    localparam int unsigned XLEN = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mdu_alu_sequencer_if #(.XLEN(XLEN)) bus ();

    mdu_alu_sequencer #(
        .XLEN       (XLEN),
        .EARLY_ZERO (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    // Shared execute-stage ALU
    always_comb begin
        case (bus.alu_ctrl)
            4'b0000: bus.alu_result = bus.alu_a + bus.alu_b;
            4'b0001: bus.alu_result = bus.alu_a - bus.alu_b;
            default: bus.alu_result = '0;
        endcase
        bus.alu_u_less = bus.alu_a < bus.alu_b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[1]) return b == 32'd0;
        return (a == 32'd0) || (b == 32'd0);
    endfunction

    // Present a request at negedge; returns #1 after the accepting edge
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'($urandom);
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
    endtask

    // Waits (bounded) for rsp_valid; edges counts the accepting edge as 1
    task automatic collect(input logic [1:0] op, output logic [31:0] data, output int edges, output int own);
        edges = 1;
        own   = bus.alu_own ? 1 : 0;
        check("alu_ctrl_first", 32'(bus.alu_ctrl), (own == 1) ? (op[1] ? 32'd1 : 32'd0) : 32'd0);
        while (!bus.rsp_valid && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.alu_own) own++;
        end
        check("rsp_valid_seen", 32'(bus.rsp_valid), 32'd1);
        data = bus.rsp_data;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] data;
        int          edges;
        int          own;
        bit          f;
        f = is_fast(op, a, b);
        issue(op, a, b);
        collect(op, data, edges, own);
        check({tag, "_data"}, data, model(op, a, b));
        check({tag, "_latency"}, 32'(edges), f ? 32'd1 : 32'd33);
        check({tag, "_own_cycles"}, 32'(own), f ? 32'd0 : 32'd32);
        check({tag, "_alu_a_idle"}, bus.alu_a, 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_back_idle"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_valid_low"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    // Abort a DIVU at its 10th iteration edge via flush (use_rst=0) or reset (use_rst=1)
    task automatic abort_div(input string tag, input bit use_rst);
        bit seen;
        issue(2'd2, 32'hDEAD_BEEF, 32'd12345);
        repeat (9) @(posedge clk);
        #1;
        check({tag, "_own_mid"}, 32'(bus.alu_own), 32'd1);
        if (use_rst) rst_n = 1'b0;
        else         flush = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        flush = 1'b0;
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_alu_own"}, 32'(bus.alu_own), 32'd0);
        check({tag, "_alu_a"}, bus.alu_a, 32'd0);
        check({tag, "_alu_ctrl"}, 32'(bus.alu_ctrl), 32'd0);
        if (use_rst) check({tag, "_rsp_data"}, bus.rsp_data, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) seen = 1'b1;
        end
        check({tag, "_no_rsp"}, 32'(seen), 32'd0);
        run_op({tag, "_mul3x3"}, 2'd0, 32'd3, 32'd3);
    endtask

    initial begin
        logic [31:0] data;
        int          edges;
        int          own;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'd0);
        check("rst_alu_own", 32'(bus.alu_own), 32'd0);
        check("rst_alu_a", bus.alu_a, 32'd0);
        check("rst_alu_b", bus.alu_b, 32'd0);
        check("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
        rst_n = 1'b1;

        run_op("mul_7x6", 2'd0, 32'd7, 32'd6);
        check("mul_7x6_literal", model(2'd0, 32'd7, 32'd6), 32'd42);
        run_op("mul_ff", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("divu_100_7", 2'd2, 32'd100, 32'd7);
        run_op("remu_100_7", 2'd3, 32'd100, 32'd7);
        run_op("divu_msb", 2'd2, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("remu_msb", 2'd3, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("divu_by0", 2'd2, 32'd5, 32'd0);
        run_op("remu_by0", 2'd3, 32'd5, 32'd0);
        run_op("mulhu_zero", 2'd1, 32'd0, 32'h1234_5678);

        // Backpressure on the response
        bus.rsp_ready = 1'b0;
        issue(2'd2, 32'd100, 32'd7);
        collect(2'd2, data, edges, own);
        check("bp_data", data, 32'd14);
        check("bp_latency", 32'(edges), 32'd33);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_rsp_data", bus.rsp_data, 32'd14);
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
        check("bp_req_ready_back", 32'(bus.req_ready), 32'd1);

        abort_div("flush", 1'b0);
        abort_div("rstmid", 1'b1);

        // Randomized operations, with occasional zero operands
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0:       a = 32'd0;
                1:       b = 32'd0;
                2:       b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op("rand", op, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
